// File: rtl/alu_seq_flags_pkg.sv
// alu_seq_flags_pkg: opcodes, flag bit positions and FSM states for the sequential flag ALU
package alu_seq_flags_pkg;
  localparam logic [3:0] OP_ADD = 4'h0, OP_SUB = 4'h1, OP_ADC = 4'h2, OP_SBC = 4'h3;
  localparam logic [3:0] OP_AND = 4'h4, OP_ORR = 4'h5, OP_XOR = 4'h6, OP_MOV = 4'h7;
  localparam logic [3:0] OP_LSL = 4'h8, OP_LSR = 4'h9, OP_ASR = 4'hA, OP_MUL = 4'hB;
  localparam int FN = 3, FZ = 2, FC = 1, FV = 0;
  typedef enum logic {S_IDLE, S_MUL_BUSY} state_e;
endpackage

// File: rtl/alu_seq_flags_if.sv
// alu_seq_flags_if: operand/result handshake bundle between operand fetch, ALU and writeback
interface alu_seq_flags_if #(parameter int WIDTH = 32);
  logic in_valid, in_ready, set_flags, out_valid, out_ready;
  logic [WIDTH-1:0] a, b, result;
  logic [3:0] op, out_flags, flags_q;
  modport master(output in_valid, a, b, op, set_flags, out_ready,
                 input in_ready, out_valid, result, out_flags, flags_q);
  modport slave(input in_valid, a, b, op, set_flags, out_ready,
                output in_ready, out_valid, result, out_flags, flags_q);
endinterface

// File: rtl/alu_seq_flags_mul.sv
// alu_seq_flags_mul: WIDTH-step shift-add multiplier, low WIDTH product bits, done on last step
module alu_seq_flags_mul #(parameter int WIDTH = 32) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             done,
  output logic [WIDTH-1:0] product
);
  localparam int CW = $clog2(WIDTH) + 1;
  logic [WIDTH-1:0] mcand_q, mcand_d, mplier_q, mplier_d, acc_q, acc_d;
  logic [CW-1:0] cnt_q, cnt_d;
  // product includes the step taking place on the current edge so the top can load it directly
  assign product = acc_q + (mplier_q[0] ? mcand_q : '0);
  assign done = cnt_q == CW'(1);
  always_comb begin
    mcand_d = mcand_q;
    mplier_d = mplier_q;
    acc_d = acc_q;
    cnt_d = cnt_q;
    if (start) begin
      mcand_d = a;
      mplier_d = b;
      acc_d = '0;
      cnt_d = CW'(WIDTH);
    end else if (cnt_q != '0) begin
      mcand_d = mcand_q << 1;
      mplier_d = mplier_q >> 1;
      acc_d = product;
      cnt_d = cnt_q - CW'(1);
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcand_q <= '0;
      mplier_q <= '0;
      acc_q <= '0;
      cnt_q <= '0;
    end else begin
      mcand_q <= mcand_d;
      mplier_q <= mplier_d;
      acc_q <= acc_d;
      cnt_q <= cnt_d;
    end
  end
endmodule

// File: rtl/alu_seq_flags.sv
// alu_seq_flags: registered execute ALU with valid/ready, persistent ZNCV register and iterative MUL
module alu_seq_flags import alu_seq_flags_pkg::*; #(
  parameter int WIDTH  = 32,
  parameter bit MUL_EN = 1'b1
) (
  input logic clk,
  input logic rst_n,
  alu_seq_flags_if.slave bus
);
  localparam int SHW = $clog2(WIDTH);
  state_e state_q, state_d;
  logic out_valid_q, out_valid_d, sf_q, sf_d;
  logic [WIDTH-1:0] result_q, result_d, alu_r, product;
  logic [3:0] oflags_q, oflags_d, flag_q, flag_d, alu_f, mul_f;
  logic [WIDTH:0] ext;
  logic [SHW-1:0] sh;
  logic accept, is_mul, defined, cin, c, v, mul_done;
  assign bus.in_ready = state_q == S_IDLE && (!out_valid_q || bus.out_ready);
  assign accept = bus.in_valid && bus.in_ready;
  assign is_mul = MUL_EN && bus.op == OP_MUL;
  assign defined = bus.op < OP_MUL || is_mul;
  assign sh = bus.b[SHW-1:0];
  assign cin = flag_q[FC] && (bus.op == OP_ADC || bus.op == OP_SBC);
  assign bus.out_valid = out_valid_q;
  assign bus.result = result_q;
  assign bus.out_flags = oflags_q;
  assign bus.flags_q = flag_q;
  alu_seq_flags_mul #(.WIDTH(WIDTH)) u_mul (
    .clk(clk), .rst_n(rst_n), .start(accept && is_mul),
    .a(bus.a), .b(bus.b), .done(mul_done), .product(product)
  );
  // shifts run one bit wider so the last bit shifted out lands in ext[WIDTH] or ext[0]
  always_comb begin
    ext = '0;
    alu_r = '0;
    c = flag_q[FC];
    v = flag_q[FV];
    case (bus.op)
      OP_ADD, OP_ADC: begin
        ext = {1'b0, bus.a} + {1'b0, bus.b} + {{WIDTH{1'b0}}, cin};
        alu_r = ext[WIDTH-1:0];
        c = ext[WIDTH];
        v = ~(bus.a[WIDTH-1] ^ bus.b[WIDTH-1]) & (bus.a[WIDTH-1] ^ ext[WIDTH-1]);
      end
      OP_SUB, OP_SBC: begin
        ext = {1'b0, bus.a} - {1'b0, bus.b} - {{WIDTH{1'b0}}, cin};
        alu_r = ext[WIDTH-1:0];
        c = ext[WIDTH];
        v = (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]) & (bus.a[WIDTH-1] ^ ext[WIDTH-1]);
      end
      OP_AND: alu_r = bus.a & bus.b;
      OP_ORR: alu_r = bus.a | bus.b;
      OP_XOR: alu_r = bus.a ^ bus.b;
      OP_MOV: alu_r = bus.b;
      OP_LSL: begin
        ext = {1'b0, bus.a} << sh;
        alu_r = ext[WIDTH-1:0];
        c = sh == '0 ? flag_q[FC] : ext[WIDTH];
      end
      OP_LSR: begin
        ext = {bus.a, 1'b0} >> sh;
        alu_r = ext[WIDTH:1];
        c = sh == '0 ? flag_q[FC] : ext[0];
      end
      OP_ASR: begin
        ext = $unsigned($signed({bus.a, 1'b0}) >>> sh);
        alu_r = ext[WIDTH:1];
        c = sh == '0 ? flag_q[FC] : ext[0];
      end
      default: alu_r = '0;
    endcase
    alu_f = defined ? {alu_r[WIDTH-1], alu_r == '0, c, v} : 4'b0000;
  end
  assign mul_f = {product[WIDTH-1], product == '0, flag_q[FC], flag_q[FV]};
  always_comb begin
    state_d = state_q;
    out_valid_d = out_valid_q && !bus.out_ready;
    result_d = result_q;
    oflags_d = oflags_q;
    flag_d = flag_q;
    sf_d = sf_q;
    if (accept && is_mul) begin
      state_d = S_MUL_BUSY;
      sf_d = bus.set_flags;
    end else if (accept) begin
      out_valid_d = 1'b1;
      result_d = alu_r;
      oflags_d = alu_f;
      flag_d = bus.set_flags && defined ? alu_f : flag_q;
    end else if (state_q == S_MUL_BUSY && mul_done) begin
      state_d = S_IDLE;
      out_valid_d = 1'b1;
      result_d = product;
      oflags_d = mul_f;
      flag_d = sf_q ? mul_f : flag_q;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      out_valid_q <= 1'b0;
      result_q <= '0;
      oflags_q <= '0;
      flag_q <= '0;
      sf_q <= 1'b0;
    end else begin
      state_q <= state_d;
      out_valid_q <= out_valid_d;
      result_q <= result_d;
      oflags_q <= oflags_d;
      flag_q <= flag_d;
      sf_q <= sf_d;
    end
  end
endmodule

// File: tb/tb_alu_seq_flags.sv
// tb_alu_seq_flags: directed vectors with a result/flag scoreboard drained by an output monitor
module tb_alu_seq_flags;
  import alu_seq_flags_pkg::*;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  alu_seq_flags_if #(.WIDTH(32)) bus();
  alu_seq_flags #(.WIDTH(32), .MUL_EN(1'b1)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  typedef struct packed {logic [31:0] r; logic [3:0] f;} exp_t;
  exp_t sb[$];
  exp_t e;
  int checks = 0, errors = 0;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  task automatic send(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                      input logic sf, input logic [31:0] r, input logic [3:0] f);
    bit ok = 1'b0;
    bus.in_valid = 1'b1;
    bus.op = op;
    bus.a = a;
    bus.b = b;
    bus.set_flags = sf;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge clk);
      ok = bus.in_ready;
      @(posedge clk);
      #1;
    end
    bus.in_valid = 1'b0;
    bus.a = 32'hDEAD_BEEF;
    bus.b = 32'hDEAD_BEEF;
    if (ok) sb.push_back({r, f});
    else begin
      checks++;
      errors++;
      $display("FAIL accept_timeout op %h", op);
    end
  endtask
  task automatic mul_wait(input int exp_n);
    int n = 0;
    bit quiet = 1'b1;
    while (!bus.out_valid && n < 100) begin
      if (bus.in_ready) quiet = 1'b0;
      @(posedge clk);
      #1;
      n++;
    end
    chk("mul_latency", n, exp_n);
    chk("mul_in_ready_low", {31'b0, quiet}, 1);
  endtask
  initial forever begin
    @(negedge clk);
    if (rst_n && bus.out_valid && bus.out_ready) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_output got %h expected none", bus.result);
      end else begin
        e = sb.pop_front();
        chk("result", bus.result, e.r);
        chk("out_flags", {28'b0, bus.out_flags}, {28'b0, e.f});
      end
    end
  end
  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end
  initial begin
    bus.in_valid = 1'b0;
    bus.op = OP_ADD;
    bus.a = '0;
    bus.b = '0;
    bus.set_flags = 1'b0;
    bus.out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", {31'b0, bus.out_valid}, 0);
    chk("rst_result", bus.result, 0);
    chk("rst_out_flags", {28'b0, bus.out_flags}, 0);
    chk("rst_flags_q", {28'b0, bus.flags_q}, 0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("rst_in_ready", {31'b0, bus.in_ready}, 1);
    send(OP_ADD, 32'h7FFF_FFFF, 32'h1, 1'b1, 32'h8000_0000, 4'b1001);
    chk("add_latency", {31'b0, bus.out_valid}, 1);
    chk("add_flags_q", {28'b0, bus.flags_q}, 32'h9);
    send(OP_SUB, 32'd3, 32'd5, 1'b1, 32'hFFFF_FFFE, 4'b1010);
    send(OP_SBC, 32'd10, 32'd2, 1'b1, 32'd7, 4'b0000);
    chk("sbc_flags_q", {28'b0, bus.flags_q}, 32'h0);
    send(OP_SUB, 32'd0, 32'd1, 1'b1, 32'hFFFF_FFFF, 4'b1010);
    send(OP_ADC, 32'hFFFF_FFFF, 32'd0, 1'b1, 32'd0, 4'b0110);
    chk("adc_flags_q", {28'b0, bus.flags_q}, 32'h6);
    send(OP_ADD, 32'h7FFF_FFFF, 32'h1, 1'b1, 32'h8000_0000, 4'b1001);
    send(OP_AND, 32'h0000_F0F0, 32'h0000_0FF0, 1'b0, 32'h0000_00F0, 4'b0001);
    chk("and_flags_kept", {28'b0, bus.flags_q}, 32'h9);
    send(OP_ORR, 32'd0, 32'd0, 1'b1, 32'd0, 4'b0101);
    send(OP_XOR, 32'hFFFF_0000, 32'h0F0F_0F0F, 1'b1, 32'hF0F0_0F0F, 4'b1001);
    send(OP_MOV, 32'd0, 32'h1234_5678, 1'b0, 32'h1234_5678, 4'b0001);
    send(OP_LSL, 32'h8000_0001, 32'd1, 1'b1, 32'h0000_0002, 4'b0011);
    send(OP_LSR, 32'h0000_0003, 32'd1, 1'b1, 32'h0000_0001, 4'b0011);
    send(OP_LSL, 32'h0000_1234, 32'h20, 1'b1, 32'h0000_1234, 4'b0011);
    send(OP_ASR, 32'h8000_0008, 32'd4, 1'b1, 32'hF800_0000, 4'b1011);
    chk("asr_flags_q", {28'b0, bus.flags_q}, 32'hB);
    send(OP_MUL, 32'h0001_0000, 32'h0001_0000, 1'b1, 32'd0, 4'b0111);
    mul_wait(32);
    chk("mul_flags_q", {28'b0, bus.flags_q}, 32'h7);
    send(OP_MUL, 32'h0001_2345, 32'd3, 1'b0, 32'h0003_69CF, 4'b0011);
    mul_wait(32);
    send(OP_MUL, 32'hFFFF_FFFF, 32'd2, 1'b1, 32'hFFFF_FFFE, 4'b1011);
    mul_wait(32);
    repeat (2) @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    send(OP_ADD, 32'd1, 32'd2, 1'b0, 32'd3, 4'b0000);
    fork
      begin
        send(OP_XOR, 32'd5, 32'd5, 1'b0, 32'd0, 4'b0111);
        send(OP_MOV, 32'd0, 32'h8000_0000, 1'b0, 32'h8000_0000, 4'b1011);
      end
      begin
        repeat (5) begin
          @(negedge clk);
          chk("stall_hold", bus.result, 32'd3);
          chk("stall_in_ready", {31'b0, bus.in_ready}, 0);
        end
        @(posedge clk);
        #1;
        bus.out_ready = 1'b1;
      end
    join
    repeat (3) @(posedge clk);
    #1;
    chk("stall_flags_q", {28'b0, bus.flags_q}, 32'hB);
    send(OP_MUL, 32'd3, 32'd3, 1'b1, 32'd9, 4'b0011);
    void'(sb.pop_back());
    repeat (10) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("abort_out_valid", {31'b0, bus.out_valid}, 0);
    chk("abort_flags_q", {28'b0, bus.flags_q}, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (40) @(posedge clk);
    #1;
    chk("abort_no_output", {31'b0, bus.out_valid}, 0);
    send(OP_SUB, 32'd3, 32'd5, 1'b1, 32'hFFFF_FFFE, 4'b1010);
    send(4'hF, 32'd5, 32'd6, 1'b1, 32'd0, 4'b0000);
    chk("undef_flags_q", {28'b0, bus.flags_q}, 32'hA);
    repeat (5) @(posedge clk);
    #1;
    chk("scoreboard_empty", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
